// File: rtl/gray_ptr_fifo.sv
// -----------------------------------------------------------------------------
// gray_ptr_fifo
//
// Single-clock synchronous FIFO whose read and write pointers are held and
// exported as (ADDR_WIDTH+1)-bit Gray codes. Each exported pointer moves by
// exactly one bit per accepted access, which lets downstream Gray decoders and
// future clock-domain-crossing stages sample them safely.
//
// Ports:
//   clk          single clock, all state changes on the rising edge
//   rst          synchronous, active-high reset
//   wr_en        write request; accepted only when not full
//   wr_data      word stored on an accepted write
//   rd_en        read request; accepted only when not empty
//   rd_data      registered read word, valid the cycle after an accepted read
//   full         registered full flag
//   empty        registered empty flag
//   wr_ptr_gray  registered Gray-coded write pointer (wrap bit included)
//   rd_ptr_gray  registered Gray-coded read pointer (wrap bit included)
//   count        registered occupancy, 0 .. 2**ADDR_WIDTH
//   overflow     one-cycle pulse after a write requested while full
//   underflow    one-cycle pulse after a read requested while empty
// -----------------------------------------------------------------------------
module gray_ptr_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage: plain array, written and read only from clocked processes so it
  // maps onto block RAM with a registered read port.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]      wbin_q, wbin_d;
  logic [PTR_W-1:0]      rbin_q, rbin_d;
  logic [PTR_W-1:0]      wgray_q, wgray_d;
  logic [PTR_W-1:0]      rgray_q, rgray_d;
  logic [PTR_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  wr_accept;
  logic                  rd_accept;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Acceptance uses the flags registered before this edge.
    wr_accept   = wr_en && !full_q;
    rd_accept   = rd_en && !empty_q;

    wbin_d      = wbin_q;
    rbin_d      = rbin_q;
    count_d     = count_q;

    if (wr_accept) begin
      wbin_d = wbin_q + PTR_W'(1);
    end
    if (rd_accept) begin
      rbin_d = rbin_q + PTR_W'(1);
    end

    // Simultaneous accepted read and write leave occupancy unchanged.
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase

    wgray_d     = wbin_d ^ (wbin_d >> 1);
    rgray_d     = rbin_d ^ (rbin_d >> 1);

    // Equal Gray pointers mean empty; full is the same address one lap ahead,
    // which in Gray code shows up as the top two bits inverted.
    empty_d     = (wgray_d == rgray_d);
    full_d      = (wgray_d == {~rgray_d[ADDR_WIDTH:ADDR_WIDTH-1],
                               rgray_d[ADDR_WIDTH-2:0]});

    overflow_d  = wr_en && full_q;
    underflow_d = rd_en && empty_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q      <= '0;
      rbin_q      <= '0;
      wgray_q     <= '0;
      rgray_q     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      rbin_q      <= rbin_d;
      wgray_q     <= wgray_d;
      rgray_q     <= rgray_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wbin_q[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // Registered read port; holds its value when no read is accepted. The read
  // uses the pre-edge read pointer, so a same-cycle write into an empty FIFO
  // is never visible here.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_accept) begin
      rd_data_q <= mem[rbin_q[ADDR_WIDTH-1:0]];
    end
  end

  assign rd_data     = rd_data_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign wr_ptr_gray = wgray_q;
  assign rd_ptr_gray = rgray_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_gray_ptr_fifo.sv
// -----------------------------------------------------------------------------
// tb_gray_ptr_fifo
//
// Self-checking bench for gray_ptr_fifo. A queue-based reference model predicts
// every registered output each cycle; directed phases cover reset, partial
// fill, full/overflow, underflow and simultaneous access, and a randomized
// stream exercises wrap-around and the single-bit Gray step property.
// -----------------------------------------------------------------------------
module tb_gray_ptr_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          full;
  logic          empty;
  logic [AW:0]   wr_ptr_gray;
  logic [AW:0]   rd_ptr_gray;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  gray_ptr_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .full        (full),
    .empty       (empty),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] m_q[$];
  int            m_wptr;     // accepted-write count modulo 2*DEPTH
  int            m_rptr;
  logic [DW-1:0] m_rd;
  logic          m_ovf;
  logic          m_unf;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_wraps = 0;
  int rd_wraps = 0;
  int reads_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int p);
    logic [AW:0] b;
    b = p[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check_all();
    check("count", 32'(count), 32'(m_q.size()));
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("full", 32'(full), 32'(m_q.size() == DEPTH));
    check("wr_gray", 32'(wr_ptr_gray), 32'(to_gray(m_wptr)));
    check("rd_gray", 32'(rd_ptr_gray), 32'(to_gray(m_rptr)));
    check("rd_data", 32'(rd_data), 32'(m_rd));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // One clock of traffic: predict, clock, then compare everything.
  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
    logic        wa, ra;
    logic [AW:0] pw, pr;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    pw = wr_ptr_gray;
    pr = rd_ptr_gray;
    wa = we && (m_q.size() < DEPTH);
    ra = re && (m_q.size() > 0);
    m_ovf = we && !wa;
    m_unf = re && !ra;
    if (ra) begin
      m_rd   = m_q.pop_front();
      m_rptr = (m_rptr + 1) % (2 * DEPTH);
      reads_done++;
    end
    if (wa) begin
      m_q.push_back(wd);
      m_wptr = (m_wptr + 1) % (2 * DEPTH);
    end
    @(posedge clk);
    #1;
    check_all();
    check("wr_gray_step", 32'($countones(pw ^ wr_ptr_gray)), 32'(wa ? 1 : 0));
    check("rd_gray_step", 32'($countones(pr ^ rd_ptr_gray)), 32'(ra ? 1 : 0));
    if (pw == 5'b10000 && wr_ptr_gray == 5'b00000) wr_wraps++;
    if (pr == 5'b10000 && rd_ptr_gray == 5'b00000) rd_wraps++;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    m_q.delete();
    m_wptr = 0;
    m_rptr = 0;
    m_rd   = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    check_all();
    check("rst_wr_gray_zero", 32'(wr_ptr_gray), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
  endtask

  initial begin
    logic [DW-1:0] held;
    int cyc;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

    // Reset with both requests asserted
    do_reset();

    // Partial fill of 7 words, then drain
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    check("fill7_wgray", 32'(wr_ptr_gray), 32'h04);
    check("fill7_count", 32'(count), 32'd7);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check("drain7_data", 32'(rd_data), 32'(8'h10 + i));
    end
    check("drain7_empty", 32'(empty), 32'h1);

    // Fill to full from pointer zero, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    check("full16_flag", 32'(full), 32'h1);
    check("full16_wgray", 32'(wr_ptr_gray), 32'h18);
    check("full16_count", 32'(count), 32'd16);
    cycle(1'b1, 8'hEE, 1'b0);
    check("ovf_pulse", 32'(overflow), 32'h1);
    check("ovf_wgray", 32'(wr_ptr_gray), 32'h18);
    cycle(1'b0, 8'h00, 1'b0);
    check("ovf_cleared", 32'(overflow), 32'h0);

    // Simultaneous read/write while full: read wins, write rejected
    cycle(1'b1, 8'hDD, 1'b1);
    check("full_rw_data", 32'(rd_data), 32'h20);
    check("full_rw_count", 32'(count), 32'd15);
    check("full_rw_ovf", 32'(overflow), 32'h1);
    for (int i = 1; i < DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check("drain_full_data", 32'(rd_data), 32'(8'h20 + i));
    end

    // Simultaneous read/write while empty: write wins, no read-through
    held = rd_data;
    cycle(1'b1, 8'h55, 1'b1);
    check("empty_rw_unf", 32'(underflow), 32'h1);
    check("empty_rw_count", 32'(count), 32'd1);
    check("empty_rw_hold", 32'(rd_data), 32'(held));
    cycle(1'b0, 8'h00, 1'b1);
    check("empty_rw_data", 32'(rd_data), 32'h55);

    // Randomized stream: wrap and Gray properties
    do_reset();
    wr_wraps = 0; rd_wraps = 0; reads_done = 0;
    cyc = 0;
    while ((reads_done < 100 || wr_wraps < 3 || rd_wraps < 3) && cyc < 5000) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      cyc++;
    end
    check("stream_budget", 32'(cyc < 5000), 32'h1);
    check("wr_wraps_ge3", 32'(wr_wraps >= 3), 32'h1);
    check("rd_wraps_ge3", 32'(rd_wraps >= 3), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_ptr_fifo.md
# gray_ptr_fifo

Single-clock synchronous FIFO whose read and write pointers are held and exported as (ADDR_WIDTH+1)-bit Gray codes. It sits directly upstream of the team's Gray-to-binary converter and of future clock-domain-crossing logic. The exported `wr_ptr_gray`/`rd_ptr_gray` change by exactly one bit per accepted access, so downstream stages can sample or decode them safely. Full/empty are derived from the Gray pointers with the standard MSB-inversion comparison.

## Interface
- `DATA_WIDTH`, 8, width of each stored word
- `ADDR_WIDTH`, 4, log2 of depth; depth = 2**ADDR_WIDTH (16 by default)

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wr_en`  in  1  write request
- `wr_data`  in  DATA_WIDTH  write word, sampled when write is accepted
- `rd_en`  in  1  read request
- `rd_data`  out  DATA_WIDTH  registered read word
- `full`  out  1  registered; no further writes accepted
- `empty`  out  1  registered; no further reads accepted
- `wr_ptr_gray`  out  ADDR_WIDTH+1  registered Gray-coded write pointer
- `rd_ptr_gray`  out  ADDR_WIDTH+1  registered Gray-coded read pointer
- `count`  out  ADDR_WIDTH+1  registered occupancy, 0..2**ADDR_WIDTH
- `overflow`  out  1  one-cycle pulse: write requested while full
- `underflow`  out  1  one-cycle pulse: read requested while empty

## Operation
- Internal binary pointers `wbin`/`rbin` are ADDR_WIDTH+1 bits. Low ADDR_WIDTH bits address storage; the MSB is the wrap bit.
- Gray encoding: `gray = bin ^ (bin >> 1)`. Registered Gray outputs update on the same edge as the binary pointers.
- Write accepted iff `wr_en && !full`. Read accepted iff `rd_en && !empty`. The decision uses flag values registered before the edge.
- Accepted write: `mem[wbin[ADDR_WIDTH-1:0]] <= wr_data`, then `wbin` increments.
- Accepted read: `rd_data <= mem[rbin[ADDR_WIDTH-1:0]]`, then `rbin` increments. Without an accepted read, `rd_data` holds its value.
- Next-state flags are computed from the next Gray pointers:
  - `empty_next = (wgray_next == rgray_next)`
  - `full_next = (wgray_next == {~rgray_next[ADDR_WIDTH:ADDR_WIDTH-1], rgray_next[ADDR_WIDTH-2:0]})`
- `count` is +1 on write only, -1 on read only, and unchanged on both or neither.
- Simultaneous `wr_en` and `rd_en`:
  - When neither full nor empty, both are accepted; count and flags are unchanged.
  - When full, the read is accepted and the write is rejected (`overflow` pulses).
  - When empty, the write is accepted and the read is rejected (`underflow` pulses). There is no read-through of the same-cycle write.
- Wrap-around: pointers roll from 2**(ADDR_WIDTH+1)-1 to 0 naturally. Gray wraps from `10000` to `00000` (ADDR_WIDTH=4) with a single-bit change.
- Rejected accesses leave the pointers, memory and `count` untouched.

## Timing
- Reset (`rst`=1 at a rising edge) sets:
  - `wbin`, `rbin`, `wr_ptr_gray`, `rd_ptr_gray`, `count` = 0
  - `empty`=1, `full`=0, `rd_data`=0, `overflow`=0, `underflow`=0
- Memory contents are not reset.
- Reset has priority over any same-cycle `wr_en`/`rd_en`. Reset mid-operation discards all contents.
- Read latency: `rd_data` is valid in the cycle after the edge at which the read was accepted.
- Flag latency: a write accepted at edge N deasserts `empty` after edge N, so a read may be accepted at edge N+1. A read at edge N deasserts `full` after edge N.
- `overflow`/`underflow` are high for exactly the cycle following the offending edge. Back-to-back offending requests keep them high.
- Each Gray pointer changes in exactly one bit per accepted access and never changes otherwise.

## Test plan
- Reset check: hold `rst` 2 cycles with `wr_en`=`rd_en`=1 -> `empty`=1, `full`=0, `count`=0, both Gray pointers 5'b00000, no overflow/underflow.
- Partial fill: write 7 words 0x10..0x16 -> `wr_ptr_gray`=5'b00100, `count`=7, `empty`=0. Read 7 -> data 0x10..0x16 in order, each one cycle after its accepted read, then `empty`=1.
- Fill to full: 16 writes from empty -> `full`=1, `wr_ptr_gray`=5'b11000, `count`=16. A 17th write -> `overflow` pulses one cycle, pointer unchanged, and the 17th word is never read back.
- Underflow and simultaneous ops on empty: `rd_en` with `wr_en`=1 on an empty FIFO -> write accepted, `underflow` pulses, `count`=1, `rd_data` unchanged.
- Simultaneous ops when full: `wr_en`=`rd_en`=1 -> read returns the oldest word, write rejected, `count`=15, `full`=0.
- Wrap and Gray property: stream 100 words with random `wr_en`/`rd_en` (~50%). Check:
  - data order matches a reference queue;
  - every Gray pointer change has Hamming distance 1;
  - pointers wrap through 5'b10000 -> 5'b00000 at least three times;
  - `count` equals the queue size every cycle.
